// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package cpu_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // A lone requester wins outright; a tie goes to whoever did not win last.
  function automatic logic pick_winner(input logic [NUM_REQ-1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/mux2_1x64.sv
// 64-bit two-input multiplexer used for request steering onto the shared port.
module mux2_1x64 (
  input  logic [63:0] d0,
  input  logic [63:0] d1,
  input  logic        sel,
  output logic [63:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one of two requesters a shared memory port,
// with a bounded wait for port_ready and a one-cycle response slot.
module mem_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [DATA_W-1:0]     addr  [NUM_REQ],
  input  logic [DATA_W-1:0]     wdata [NUM_REQ],
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  port_valid,
  output logic                  port_we,
  output logic [DATA_W-1:0]     port_addr,
  output logic [DATA_W-1:0]     port_wdata,
  input  logic                  port_ready,
  input  logic [DATA_W-1:0]     port_rdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic                win;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    win     = pick_winner(req, last_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d      = win;
          last_d     = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Requester inputs are not re-examined here: dropping req mid-flight
        // does not abort the transaction.
        if (port_ready) begin
          rdata_d        = port_rdata;
          done_d[sel_q]  = 1'b1;
          gnt_d          = '0;
          state_d        = RESP;
        end else if (cnt_q == CNT_MAX) begin
          err_d[sel_q]   = 1'b1;
          gnt_d          = '0;
          state_d        = RESP;
        end else begin
          cnt_d          = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign port_valid = (state_q == BUSY);
  assign port_we    = we[sel_q];

  mux2_1x64 u_addr_mux (
    .d0  (addr[0]),
    .d1  (addr[1]),
    .sel (sel_q),
    .y   (port_addr)
  );

  mux2_1x64 u_wdata_mux (
    .d0  (wdata[0]),
    .d1  (wdata[1]),
    .sel (sel_q),
    .y   (port_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [63:0] addr [2];
  logic [63:0] wdata [2];
  logic [1:0]  gnt, done, err;
  logic [63:0] rdata;
  logic        port_valid, port_we, port_ready;
  logic [63:0] port_addr, port_wdata, port_rdata;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .port_valid(port_valid), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_ready(port_ready), .port_rdata(port_rdata)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;

  // transaction-level model: who won last, and what rdata should hold
  int          m_last;
  logic [63:0] m_rdata;

  function automatic int model_grant(input logic [1:0] r);
    if (r == 2'b11) return (m_last == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  // observations gathered by the driver
  logic [1:0]  o_gnt, o_gnt_resp, o_done, o_err, o_done_idle, o_err_idle, o_gnt_idle;
  logic [63:0] o_addr, o_wdata, o_rdata, o_rdata_idle;
  logic        o_pwe, o_stable, o_pv_resp;
  int          o_nvalid;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_last = 1; m_rdata = '0;
  endtask

  // Drives one transaction from an IDLE negedge; ready comes in BUSY cycle dly+1.
  task automatic do_txn(input logic [1:0] r, input int dly, input logic [63:0] prd,
                        input logic drop, input logic resp_ready);
    req = r;
    @(negedge clk);
    o_gnt = gnt; o_addr = port_addr; o_wdata = port_wdata; o_pwe = port_we;
    o_stable = 1'b1; o_nvalid = 0;
    if (drop) req = 2'b00;
    while (port_valid && o_nvalid < TO + 4) begin
      o_nvalid++;
      if (gnt !== o_gnt || port_addr !== o_addr || port_wdata !== o_wdata ||
          port_we !== o_pwe || done !== 2'b00 || err !== 2'b00) o_stable = 1'b0;
      port_ready = (o_nvalid == dly + 1);
      port_rdata = port_ready ? prd : {$urandom, $urandom};
      @(negedge clk);
    end
    port_ready = resp_ready; port_rdata = {$urandom, $urandom};
    o_done = done; o_err = err; o_gnt_resp = gnt; o_rdata = rdata; o_pv_resp = port_valid;
    @(negedge clk);
    port_ready = 1'b0; req = 2'b00;
    o_done_idle = done; o_err_idle = err; o_gnt_idle = gnt; o_rdata_idle = rdata;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    nvec++; if (gnt !== 2'b00) begin nmis++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    nvec++; if (done !== 2'b00 || err !== 2'b00) begin nmis++; $display("FAIL reset_done_err got=%b/%b exp=00/00", done, err); end
    nvec++; if (port_valid !== 1'b0) begin nmis++; $display("FAIL reset_port_valid got=%b exp=0", port_valid); end
    nvec++; if (rdata !== 64'h0) begin nmis++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk);
    reset = 1'b0;
    m_last = 1; m_rdata = '0;
  endtask

  task automatic test_single();
    addr[0] = 64'h1000; we = 2'b00;
    do_txn(2'b01, 0, 64'hDEAD_BEEF, 1'b0, 1'b0);
    m_last = 0; m_rdata = 64'hDEAD_BEEF;
    nvec++; if (o_gnt !== 2'b01) begin nmis++; $display("FAIL single_gnt got=%b exp=01", o_gnt); end
    nvec++; if (o_addr !== 64'h1000) begin nmis++; $display("FAIL single_addr got=%h exp=1000", o_addr); end
    nvec++; if (o_nvalid !== 1) begin nmis++; $display("FAIL single_valid_cycles got=%0d exp=1", o_nvalid); end
    nvec++; if (o_done !== 2'b01 || o_err !== 2'b00) begin nmis++; $display("FAIL single_done got=%b/%b exp=01/00", o_done, o_err); end
    nvec++; if (o_rdata !== 64'hDEAD_BEEF) begin nmis++; $display("FAIL single_rdata got=%h exp=deadbeef", o_rdata); end
    nvec++; if (o_gnt_resp !== 2'b00 || o_pv_resp !== 1'b0) begin nmis++; $display("FAIL single_resp got gnt=%b pv=%b exp=00/0", o_gnt_resp, o_pv_resp); end
    nvec++; if (o_done_idle !== 2'b00) begin nmis++; $display("FAIL single_done_width got=%b exp=00", o_done_idle); end
  endtask

  task automatic test_tie();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [63:0] prd;
      prd = {$urandom, $urandom};
      do_txn(2'b11, 0, prd, 1'b0, 1'b0);
      m_last = model_grant(2'b11); m_rdata = prd;
      nvec++; if (o_gnt !== exp_seq[i]) begin nmis++; $display("FAIL tie_gnt[%0d] got=%b exp=%b", i, o_gnt, exp_seq[i]); end
      nvec++; if (o_gnt_idle !== 2'b00) begin nmis++; $display("FAIL tie_no_early_grant[%0d] got=%b exp=00", i, o_gnt_idle); end
    end
  endtask

  task automatic test_write();
    logic [63:0] prd;
    prd = {$urandom, $urandom};
    we = 2'b10; wdata[1] = 64'hA5A5; wdata[0] = 64'h5A5A_0000; addr[1] = 64'h2000;
    do_txn(2'b10, 3, prd, 1'b0, 1'b0);
    m_last = 1; m_rdata = prd;
    nvec++; if (o_pwe !== 1'b1) begin nmis++; $display("FAIL write_port_we got=%b exp=1", o_pwe); end
    nvec++; if (o_wdata !== 64'hA5A5) begin nmis++; $display("FAIL write_wdata got=%h exp=a5a5", o_wdata); end
    nvec++; if (o_stable !== 1'b1) begin nmis++; $display("FAIL write_stable got=%b exp=1", o_stable); end
    nvec++; if (o_nvalid !== 4) begin nmis++; $display("FAIL write_valid_cycles got=%0d exp=4", o_nvalid); end
    nvec++; if (o_done !== 2'b10) begin nmis++; $display("FAIL write_done got=%b exp=10", o_done); end
    we = 2'b00;
  endtask

  task automatic test_timeout();
    logic [63:0] old;
    old = m_rdata;
    do_txn(2'b01, 1000, 64'h0BAD, 1'b0, 1'b0);
    m_last = 0;
    nvec++; if (o_nvalid !== TO) begin nmis++; $display("FAIL timeout_valid_cycles got=%0d exp=%0d", o_nvalid, TO); end
    nvec++; if (o_err !== 2'b01 || o_done !== 2'b00) begin nmis++; $display("FAIL timeout_err got=%b/%b exp=01/00", o_err, o_done); end
    nvec++; if (o_rdata !== old) begin nmis++; $display("FAIL timeout_rdata got=%h exp=%h", o_rdata, old); end
    nvec++; if (o_err_idle !== 2'b00) begin nmis++; $display("FAIL timeout_err_width got=%b exp=00", o_err_idle); end
  endtask

  task automatic test_reset_mid_busy();
    req = 2'b01;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    nvec++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00 || port_valid !== 1'b0 || rdata !== 64'h0) begin
      nmis++; $display("FAIL midreset_outputs got gnt=%b done=%b err=%b pv=%b rdata=%h exp all 0", gnt, done, err, port_valid, rdata);
    end
    @(negedge clk);
    reset = 1'b0; req = 2'b00;
    m_last = 1; m_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nvec++; if (done !== 2'b00 || err !== 2'b00 || port_valid !== 1'b0) begin
        nmis++; $display("FAIL midreset_quiet[%0d] got done=%b err=%b pv=%b exp 0", i, done, err, port_valid);
      end
    end
    do_txn(2'b11, 0, 64'h1234, 1'b0, 1'b0);
    m_last = 0; m_rdata = 64'h1234;
    nvec++; if (o_gnt !== 2'b01) begin nmis++; $display("FAIL midreset_tie got=%b exp=01", o_gnt); end
  endtask

  task automatic test_spurious_ready();
    logic [63:0] prd;
    for (int i = 0; i < 3; i++) begin
      port_ready = 1'b1; port_rdata = {$urandom, $urandom};
      @(negedge clk);
      nvec++; if (done !== 2'b00 || gnt !== 2'b00 || port_valid !== 1'b0 || rdata !== m_rdata) begin
        nmis++; $display("FAIL spurious_idle[%0d] got done=%b gnt=%b pv=%b rdata=%h exp 00/00/0/%h", i, done, gnt, port_valid, rdata, m_rdata);
      end
    end
    port_ready = 1'b0;
    prd = {$urandom, $urandom};
    do_txn(2'b10, 2, prd, 1'b0, 1'b1);
    m_last = 1; m_rdata = prd;
    nvec++; if (o_rdata_idle !== prd || o_done_idle !== 2'b00 || o_gnt_idle !== 2'b00) begin
      nmis++; $display("FAIL spurious_resp got rdata=%h done=%b gnt=%b exp %h/00/00", o_rdata_idle, o_done_idle, o_gnt_idle, prd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r, eg, ed, ee;
      logic [63:0] prd, er;
      int          dly, w, en;
      logic        drop;
      r = 2'($urandom_range(1, 3));
      we = 2'($urandom);
      for (int k = 0; k < 2; k++) begin addr[k] = {$urandom, $urandom}; wdata[k] = {$urandom, $urandom}; end
      dly = ($urandom_range(0, 3) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
      drop = 1'($urandom);
      prd = {$urandom, $urandom};
      w = model_grant(r);
      eg = '0; eg[w] = 1'b1;
      en = (dly < TO) ? dly + 1 : TO;
      ed = (dly < TO) ? eg : 2'b00;
      ee = (dly < TO) ? 2'b00 : eg;
      er = (dly < TO) ? prd : m_rdata;
      do_txn(r, dly, prd, drop, 1'($urandom));
      m_last = w; m_rdata = er;
      nvec++; if (o_gnt !== eg) begin nmis++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, o_gnt, eg); end
      nvec++; if (o_addr !== addr[w] || o_wdata !== wdata[w] || o_pwe !== we[w]) begin
        nmis++; $display("FAIL rand_steer[%0d] got %h/%h/%b exp %h/%h/%b", i, o_addr, o_wdata, o_pwe, addr[w], wdata[w], we[w]);
      end
      nvec++; if (o_nvalid !== en) begin nmis++; $display("FAIL rand_valid_cycles[%0d] got=%0d exp=%0d", i, o_nvalid, en); end
      nvec++; if (o_done !== ed || o_err !== ee) begin nmis++; $display("FAIL rand_done_err[%0d] got=%b/%b exp=%b/%b", i, o_done, o_err, ed, ee); end
      nvec++; if (o_rdata_idle !== er) begin nmis++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, o_rdata_idle, er); end
      nvec++; if (o_stable !== 1'b1 || o_gnt_resp !== 2'b00 || o_done_idle !== 2'b00 || o_err_idle !== 2'b00) begin
        nmis++; $display("FAIL rand_protocol[%0d] stable=%b gnt_resp=%b done_idle=%b err_idle=%b", i, o_stable, o_gnt_resp, o_done_idle, o_err_idle);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; port_ready = 1'b0; port_rdata = '0;
    for (int k = 0; k < 2; k++) begin addr[k] = '0; wdata[k] = '0; end
    m_last = 1; m_rdata = '0;
    test_reset();
    test_single();
    test_tie();
    test_write();
    test_timeout();
    test_reset_mid_busy();
    test_spurious_ready();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max BUSY cycles awaiting port_ready before abort (legal 2..255).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  [1:0]  per-requester transaction request (0 = fetch, 1 = load/store).
REQ-005 SHALL have port we  input  [1:0]  per-requester write enable.
REQ-006 SHALL have port addr  input  [63:0] x [1:0] unpacked  per-requester address.
REQ-007 SHALL have port wdata  input  [63:0] x [1:0] unpacked  per-requester write data.
REQ-008 SHALL have port gnt  output  [1:0]  one-hot grant, high for whole transaction.
REQ-009 SHALL have port done  output  [1:0]  one-cycle completion pulse to owner.
REQ-010 SHALL have port err  output  [1:0]  one-cycle timeout pulse to owner.
REQ-011 SHALL have port rdata  output  64  captured read data, broadcast to both requesters.
REQ-012 SHALL have ports port_valid output 1, port_we output 1, port_addr output 64, port_wdata output 64: shared resource request side.
REQ-013 SHALL have ports port_ready input 1, port_rdata input 64: shared resource completion side.

Function
REQ-014 SHALL implement states IDLE, BUSY, RESP.
REQ-015 IDLE: if any req high, SHALL register winner into sel, set gnt[winner], clear counter, go BUSY next cycle; else stay IDLE.
REQ-016 Winner: single requester wins; both high -> requester != last winner (round-robin); last updated on every grant.
REQ-017 BUSY: port_valid=1; port_addr/port_wdata = addr[sel]/wdata[sel]; port_we = we[sel].
REQ-018 BUSY with port_ready=1: SHALL capture port_rdata into rdata, go RESP, done[sel]=1 in RESP cycle.
REQ-019 BUSY with port_ready=0: counter increments; at counter == TIMEOUT-1 SHALL go RESP with err[sel]=1, done=0, rdata unchanged.
REQ-020 RESP: lasts exactly one cycle; gnt cleared; no arbitration; return to IDLE.
REQ-021 Minimum latency: req high in IDLE cycle N -> port_valid in N+1 -> port_ready at N+1 -> done in N+2; next grant earliest N+4.
REQ-022 req/we/addr/wdata of owner SHALL be held stable by requester while gnt high; req deassertion during BUSY SHALL be ignored (no abort).
REQ-023 port_ready in IDLE or RESP SHALL be ignored.
REQ-024 port_addr/port_wdata/port_we are contract-undefined when port_valid=0; port_valid SHALL be 0 outside BUSY.
REQ-025 done and err SHALL never both be high; at most one bit of gnt/done/err high in any cycle.

Reset
REQ-026 reset SHALL asynchronously force state=IDLE, gnt=0, done=0, err=0, port_valid=0, rdata=0, counter=0, sel=0.
REQ-027 reset SHALL set last winner=1 so requester 0 wins first tie.
REQ-028 reset mid-BUSY SHALL abandon the transaction with no done/err pulse after release.

Structure
REQ-029 Shared package cpu_arb_pkg SHALL hold arb_state_t enum (IDLE/BUSY/RESP), NUM_REQ=2, DATA_W=64.
REQ-030 Address and write-data steering SHALL instantiate the existing mux2_1x64 (two instances, sel driven by registered sel); control logic in one FSM.

Verification
REQ-031 Single: req=2'b01, addr[0]=64'h1000, port_ready one cycle after port_valid with port_rdata=64'hDEAD_BEEF -> gnt=01, port_addr=64'h1000, done=01 next cycle, rdata=64'hDEAD_BEEF.
REQ-032 Tie after reset: req=2'b11 held, ready immediate -> grants alternate 0,1,0,1 over four transactions.
REQ-033 Write: req=2'b10, we[1]=1, wdata[1]=64'hA5A5 -> port_we=1, port_wdata=64'hA5A5 while port_valid.
REQ-034 Timeout: TIMEOUT=16, port_ready held 0 -> port_valid exactly 16 cycles, then err[sel] pulse, done=0, rdata unchanged.
REQ-035 Reset mid-BUSY after 3 cycles -> all outputs 0 immediately; no done/err afterward; next tie granted to requester 0.
REQ-036 Spurious port_ready in IDLE and RESP -> no done, no state change.
